// File: rtl/lbp_write_buffer.sv
// Write-back stage between the LBP datapath and the result memory: a small
// valid/ready FIFO of (address, data) pairs with frame sequencing and a sticky finish flag.
module lbp_write_buffer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 14,
    parameter int LAST_ADDR = 16382,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              lbp_valid_o,
    input  logic              lbp_ready_i,
    output logic [DATA_W-1:0] lbp_data_o,
    output logic [ADDR_W-1:0] lbp_addr_o,
    output logic              busy_o,
    output logic              finish_o,
    output logic [ADDR_W:0]   wr_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W:0]   wr_count;

    logic empty, full, push, pop, start_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_C);
    assign push     = in_valid_i & in_ready_o;
    assign pop      = lbp_valid_o & lbp_ready_i;
    assign start_ok = start_i & ((state == S_IDLE) | (state == S_DONE));

    assign in_ready_o  = (state == S_RUN) & ~full;
    assign lbp_valid_o = ~empty;
    // Head is masked while empty so reset leaves the write port at zero.
    assign lbp_data_o  = empty ? '0 : mem_data[rd_ptr];
    assign lbp_addr_o  = empty ? '0 : mem_addr[rd_ptr];
    assign busy_o      = (state == S_RUN) | (state == S_DRAIN);
    assign finish_o    = (state == S_DONE);
    assign wr_count_o  = wr_count;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_RUN;
            S_RUN:   if (push && in_addr_i == LAST_A) state_nxt = S_DRAIN;
            S_DRAIN: if (pop && count == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE:  if (start_i) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wr_count <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (start_ok)  wr_count <= '0;
            else if (pop)  wr_count <= wr_count + 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data_i;
            mem_addr[wr_ptr] <= in_addr_i;
        end
    end

endmodule
